if_fetch_unit: RTL

Instruction-fetch stage of the 6-stage pipeline: owns the PC, issues requests to instruction memory, and drives the IF/ID pipeline register consumed by decode and by the load-use hazard unit. It holds on `stall` (load-use hazard), flushes and redirects on `branch_taken`, and parks a late-arriving instruction in a one-entry skid buffer. Only one memory request is ever outstanding.

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/if_skid_buf.sv | 38 +++
 rtl/if_fetch_unit.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_FULL = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_STEP   = 32'd4;

    localparam int RS_MSB = 25;
    localparam int RS_LSB = 21;
    localparam int RT_MSB = 20;
    localparam int RT_LSB = 16;

endpackage

// File: rtl/if_skid_buf.sv
// One-entry skid buffer that parks a fetched {pc, instr} while decode is stalled.
module if_skid_buf
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] load_pc,
    input  logic [31:0] load_instr,
    output logic        full,
    output logic [31:0] pc,
    output logic [31:0] instr
);

    fetch_entry_t entry;
    logic         full_q;

    // NOTE: the single data entry is reset along with the flag so a cleared
    // buffer never exposes a stale instruction on its outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            entry  <= '0;
        end else if (clear) begin
            full_q <= 1'b0;
            entry  <= '0;
        end else if (load) begin
            full_q <= 1'b1;
            entry  <= {load_pc, load_instr};
        end
    end

    assign full  = full_q;
    assign pc    = entry.pc;
    assign instr = entry.instr;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, keeps one imem request in flight and
// drives the IF/ID register, with stall hold, branch flush and a skid buffer.
module if_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [31:0]      branch_target,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_valid,
    input  logic [31:0]      imem_rdata,
    output logic             valid_if_id,
    output logic [31:0]      pc_if_id,
    output logic [31:0]      instr_if_id,
    output logic [4:0]       rs_if_id,
    output logic [4:0]       rt_if_id,
    output logic [CNT_W-1:0] stall_count
);

    fetch_state_t     state;
    logic [31:0]      fetch_pc;
    logic [31:0]      req_pc;
    logic             kill;

    logic             if_valid;
    logic [31:0]      if_pc;
    logic [31:0]      if_instr;
    logic [CNT_W-1:0] stall_cnt;

    logic             flush;
    logic             issue;
    logic             resp;
    logic             load_resp;
    logic             skid_load;
    logic             skid_drain;
    logic             skid_clear;
    logic             skid_full;
    logic [31:0]      skid_pc;
    logic [31:0]      skid_instr;

    // NOTE: combinational control assigns every output a default first, with
    // blocking assignments, so no latch can be inferred.
    always_comb begin
        flush      = 1'b0;
        issue      = 1'b0;
        resp       = 1'b0;
        load_resp  = 1'b0;
        skid_load  = 1'b0;
        skid_drain = 1'b0;

        flush = branch_taken && (state != S_IDLE);
        // A branch ignores stall, so a request still goes out and is killed later.
        issue = (state == S_REQ) && (branch_taken || !stall);
        resp  = (state == S_WAIT) && imem_valid;

        load_resp  = resp && !kill && !branch_taken && !stall;
        skid_load  = resp && !kill && !branch_taken && stall;
        skid_drain = (state == S_FULL) && skid_full && !stall && !branch_taken;
    end

    assign skid_clear = flush || skid_drain;

    if_skid_buf u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (skid_load),
        .clear      (skid_clear),
        .load_pc    (req_pc),
        .load_instr (imem_rdata),
        .full       (skid_full),
        .pc         (skid_pc),
        .instr      (skid_instr)
    );

    // NOTE: all sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            fetch_pc <= RESET_PC;
            req_pc   <= 32'h0;
            kill     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: state <= S_REQ;

                S_REQ: begin
                    if (branch_taken) begin
                        fetch_pc <= branch_target;
                        kill     <= 1'b1;
                        state    <= S_WAIT;
                    end else if (!stall) begin
                        req_pc   <= fetch_pc;
                        fetch_pc <= fetch_pc + PC_STEP;
                        state    <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (branch_taken) begin
                        fetch_pc <= branch_target;
                        if (imem_valid) begin
                            kill  <= 1'b0;
                            state <= S_REQ;
                        end else begin
                            kill  <= 1'b1;
                        end
                    end else if (imem_valid) begin
                        if (kill) begin
                            kill  <= 1'b0;
                            state <= S_REQ;
                        end else if (stall) begin
                            state <= S_FULL;
                        end else begin
                            state <= S_REQ;
                        end
                    end
                end

                S_FULL: begin
                    if (branch_taken) begin
                        fetch_pc <= branch_target;
                        state    <= S_REQ;
                    end else if (!stall) begin
                        state    <= S_REQ;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

    // IF/ID register: flush beats a fresh response, which beats a skid drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_valid <= 1'b0;
            if_pc    <= 32'h0;
            if_instr <= NOP_INSTR;
        end else if (flush) begin
            if_valid <= 1'b0;
            if_pc    <= 32'h0;
            if_instr <= NOP_INSTR;
        end else if (load_resp) begin
            if_valid <= 1'b1;
            if_pc    <= req_pc;
            if_instr <= imem_rdata;
        end else if (skid_drain) begin
            if_valid <= 1'b1;
            if_pc    <= skid_pc;
            if_instr <= skid_instr;
        end else if (!stall) begin
            if_valid <= 1'b0;
            if_pc    <= 32'h0;
            if_instr <= NOP_INSTR;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stall && if_valid && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign imem_req    = issue;
    assign imem_addr   = fetch_pc;
    assign valid_if_id = if_valid;
    assign pc_if_id    = if_pc;
    assign instr_if_id = if_instr;
    assign rs_if_id    = if_instr[RS_MSB:RS_LSB];
    assign rt_if_id    = if_instr[RT_MSB:RT_LSB];
    assign stall_count = stall_cnt;

endmodule
